irq_timer_ctrl: RTL and testbench

Programmable raster-timer controller that drives the timer interrupt and the IRQ-acknowledge inputs of the interrupt synchroniser. It holds the CPU-visible timer reload value and the timer mode bits. It runs a 32-bit down-counter on the pixel clock enable and issues TIMER_IRQ pulses. It also converts CPU writes to the IRQ-ack register into the WR_ACK/ACK_BITS strobe.

---
 rtl/irq_timer_ctrl_if.sv | 24 ++
 rtl/irq_timer_ctrl.sv | 120 ++++++++++++
 tb/tb_irq_timer_ctrl.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/irq_timer_ctrl_if.sv
// CPU write port, pixel/vblank strobes and timer/ack outputs of irq_timer_ctrl.
// master drives the write port and strobes; slave is the timer controller.
interface irq_timer_ctrl_if;
  logic        CLK_EN;
  logic        WR_EN;
  logic [1:0]  WR_SEL;
  logic [15:0] WR_DATA;
  logic        VBL_START;
  logic        TIMER_IRQ;
  logic        TIMER_IRQ_EN;
  logic        WR_ACK;
  logic [2:0]  ACK_BITS;
  logic [31:0] TIMER_CNT;

  modport master (
    output CLK_EN, WR_EN, WR_SEL, WR_DATA, VBL_START,
    input  TIMER_IRQ, TIMER_IRQ_EN, WR_ACK, ACK_BITS, TIMER_CNT
  );

  modport slave (
    input  CLK_EN, WR_EN, WR_SEL, WR_DATA, VBL_START,
    output TIMER_IRQ, TIMER_IRQ_EN, WR_ACK, ACK_BITS, TIMER_CNT
  );
endinterface

// File: rtl/irq_timer_ctrl.sv
// Raster timer: 32-bit down-counter on CLK_EN with IRQ pulses, plus IRQ-ack strobe; writes act in 1 CLK, no backpressure.
// Optional TIMER_VBL_RELOAD_EN makes mode bit 6 (reload at VBL_START) functional.
module irq_timer_ctrl (
  input  logic              CLK,
  input  logic              RESET,
  irq_timer_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

  state_t      state_q, state_d;
  logic [3:0]  mode_q;        // {RLD_ZERO, RLD_VBL, RLD_WR, EN}
  logic [15:0] rld_hi_q;
  logic [15:0] rld_lo_q;
  logic [31:0] cnt_q, cnt_d;
  logic        irq_q, irq_d;
  logic        wr_ack_q;
  logic [2:0]  ack_bits_q;

  logic        wr_mode, wr_hi, wr_lo, wr_ackreg;
  logic        en_on, en_off;
  logic        ev_wr, ev_vbl;
  logic        at_zero, expire;
  logic [31:0] reload_val;

  assign wr_mode   = bus.WR_EN && (bus.WR_SEL == 2'd0);
  assign wr_hi     = bus.WR_EN && (bus.WR_SEL == 2'd1);
  assign wr_lo     = bus.WR_EN && (bus.WR_SEL == 2'd2);
  assign wr_ackreg = bus.WR_EN && (bus.WR_SEL == 2'd3);

  assign en_on  = wr_mode &&  bus.WR_DATA[4];
  assign en_off = wr_mode && !bus.WR_DATA[4];

  assign reload_val = {rld_hi_q, rld_lo_q};
  assign ev_wr      = wr_lo && mode_q[1];

`ifdef TIMER_VBL_RELOAD_EN
  assign ev_vbl = bus.VBL_START && mode_q[2];
`else
  logic vbl_unused;
  assign vbl_unused = bus.VBL_START;
  assign ev_vbl     = 1'b0;
`endif

  assign at_zero = (cnt_q == 32'd0);
  // A disabling mode write in the same cycle suppresses the expiry.
  assign expire  = (state_q == RUN) && bus.CLK_EN && at_zero && !en_off;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    irq_d   = irq_q;
    if (bus.CLK_EN) irq_d = expire;
    case (state_q)
      IDLE: begin
        if (en_on) state_d = RUN;
      end
      RUN: begin
        if (ev_wr) begin
          cnt_d = {rld_hi_q, bus.WR_DATA};
        end else if (ev_vbl) begin
          cnt_d = reload_val;
        end else if (bus.CLK_EN) begin
          if (!at_zero)       cnt_d = cnt_q - 32'd1;
          else if (mode_q[3]) cnt_d = reload_val;
          else                state_d = HOLD;
        end
      end
      HOLD: begin
        if (ev_wr) begin
          cnt_d   = {rld_hi_q, bus.WR_DATA};
          state_d = RUN;
        end else if (ev_vbl) begin
          cnt_d   = reload_val;
          state_d = RUN;
        end
      end
      default: state_d = IDLE;
    endcase
    if (en_off) begin
      state_d = IDLE;
      cnt_d   = cnt_q;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= IDLE;
      cnt_q   <= 32'd0;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      irq_q   <= irq_d;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      mode_q     <= 4'd0;
      rld_hi_q   <= 16'd0;
      rld_lo_q   <= 16'd0;
      wr_ack_q   <= 1'b1;
      ack_bits_q <= 3'd0;
    end else begin
      if (wr_mode) mode_q   <= bus.WR_DATA[7:4];
      if (wr_hi)   rld_hi_q <= bus.WR_DATA;
      if (wr_lo)   rld_lo_q <= bus.WR_DATA;
      if (wr_ackreg) ack_bits_q <= bus.WR_DATA[2:0];
      wr_ack_q <= !wr_ackreg;
    end
  end

  assign bus.TIMER_IRQ    = irq_q;
  assign bus.TIMER_IRQ_EN = mode_q[0];
  assign bus.WR_ACK       = wr_ack_q;
  assign bus.ACK_BITS     = ack_bits_q;
  assign bus.TIMER_CNT    = cnt_q;

endmodule

// File: tb/tb_irq_timer_ctrl.sv
// Scoreboard bench for irq_timer_ctrl: stimulus queues expected output snapshots per cycle, a negedge monitor compares.
module tb_irq_timer_ctrl;

  logic CLK = 1'b0;
  logic RESET = 1'b1;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  irq_timer_ctrl_if bus ();

  irq_timer_ctrl dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  localparam logic [4:0] M_CNT = 5'd1, M_IRQ = 5'd2, M_ACK = 5'd4, M_BITS = 5'd8, M_EN = 5'd16;
  localparam logic [4:0] M_ALL = 5'd31;

  typedef struct {
    int          cyc;
    string       nm;
    logic [4:0]  m;
    logic [31:0] cnt;
    logic        irq;
    logic        ack;
    logic [2:0]  bits;
    logic        en;
  } exp_t;

  exp_t sb[$];

  function automatic void push(int d, string nm, logic [4:0] m, logic [31:0] cnt,
                               logic irq, logic ack, logic [2:0] bits, logic en);
    exp_t e;
    e.cyc = cyc + d; e.nm = nm; e.m = m; e.cnt = cnt;
    e.irq = irq; e.ack = ack; e.bits = bits; e.en = en;
    sb.push_back(e);
  endfunction

  function automatic void chk(string nm, string fld, logic [31:0] act, logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s.%s: got %h required %h (cycle %0d)", nm, fld, act, req, cyc);
    end
  endfunction

  // Monitor: compares every queued snapshot whose cycle has arrived.
  always @(negedge CLK) begin
    exp_t e;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      if (e.cyc < cyc) begin
        n_chk++; n_fail++;
        $display("FAIL %s: check for cycle %0d missed", e.nm, e.cyc);
      end else begin
        if (e.m[0]) chk(e.nm, "TIMER_CNT",    bus.TIMER_CNT,             e.cnt);
        if (e.m[1]) chk(e.nm, "TIMER_IRQ",    {31'd0, bus.TIMER_IRQ},    {31'd0, e.irq});
        if (e.m[2]) chk(e.nm, "WR_ACK",       {31'd0, bus.WR_ACK},       {31'd0, e.ack});
        if (e.m[3]) chk(e.nm, "ACK_BITS",     {29'd0, bus.ACK_BITS},     {29'd0, e.bits});
        if (e.m[4]) chk(e.nm, "TIMER_IRQ_EN", {31'd0, bus.TIMER_IRQ_EN}, {31'd0, e.en});
      end
    end
  end

  task automatic step(int n = 1);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  // One-cycle register write; on return the write's effect is visible this cycle (d=0).
  task automatic wr(logic [1:0] sel, logic [15:0] data);
    bus.WR_EN = 1'b1; bus.WR_SEL = sel; bus.WR_DATA = data;
    step();
    bus.WR_EN = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.CLK_EN = 1'b0; bus.WR_EN = 1'b0; bus.WR_SEL = 2'd0;
    bus.WR_DATA = 16'd0; bus.VBL_START = 1'b0;

    // Reset values
    step();
    push(0, "reset", M_ALL, 32'd0, 1'b0, 1'b1, 3'd0, 1'b0);
    step();
    RESET = 1'b0;
    step();

    // Periodic mode: RELOAD=3, EN+RLD_ZERO
    wr(2'd1, 16'h0000);
    wr(2'd2, 16'h0003);
    push(0, "idle_frozen", M_CNT | M_EN, 32'd0, 1'b0, 1'b1, 3'd0, 1'b0);
    wr(2'd0, 16'h0090);
    push(0, "mode90", M_CNT | M_IRQ | M_EN, 32'd0, 1'b0, 1'b1, 3'd0, 1'b1);
    bus.CLK_EN = 1'b1;
    push(1, "per_t1", M_CNT | M_IRQ, 32'd3, 1'b1, 1'b1, 3'd0, 1'b0);
    push(2, "per_t2", M_CNT | M_IRQ, 32'd2, 1'b0, 1'b1, 3'd0, 1'b0);
    push(3, "per_t3", M_CNT | M_IRQ, 32'd1, 1'b0, 1'b1, 3'd0, 1'b0);
    push(4, "per_t4", M_CNT | M_IRQ, 32'd0, 1'b0, 1'b1, 3'd0, 1'b0);
    push(5, "per_t5", M_CNT | M_IRQ, 32'd3, 1'b1, 1'b1, 3'd0, 1'b0);
    push(6, "per_t6", M_CNT | M_IRQ, 32'd2, 1'b0, 1'b1, 3'd0, 1'b0);
    step(6);
    bus.CLK_EN = 1'b0;

    // Ack strobe, single then back-to-back
    wr(2'd3, 16'h0005);
    push(0, "ack_lo", M_ACK | M_BITS | M_CNT, 32'd2, 1'b0, 1'b0, 3'b101, 1'b0);
    push(1, "ack_hi", M_ACK | M_BITS, 32'd0, 1'b0, 1'b1, 3'b101, 1'b0);
    step(2);
    wr(2'd3, 16'h0002);
    push(0, "ack_b2b_1", M_ACK | M_BITS, 32'd0, 1'b0, 1'b0, 3'b010, 1'b0);
    wr(2'd3, 16'hFFFF);
    push(0, "ack_b2b_2", M_ACK | M_BITS, 32'd0, 1'b0, 1'b0, 3'b111, 1'b0);
    push(1, "ack_b2b_end", M_ACK | M_BITS, 32'd0, 1'b0, 1'b1, 3'b111, 1'b0);
    step();

    // EN cleared at count 5, then resumed
    wr(2'd1, 16'h0000);
    wr(2'd0, 16'h0030);
    wr(2'd2, 16'h0007);
    push(0, "rld7", M_CNT, 32'd7, 1'b0, 1'b1, 3'd0, 1'b1);
    bus.CLK_EN = 1'b1;
    push(1, "cnt6", M_CNT, 32'd6, 1'b0, 1'b1, 3'd0, 1'b1);
    push(2, "cnt5", M_CNT, 32'd5, 1'b0, 1'b1, 3'd0, 1'b1);
    step(2);
    wr(2'd0, 16'h0000);
    push(0, "dis_frz", M_CNT | M_IRQ | M_EN, 32'd5, 1'b0, 1'b1, 3'd0, 1'b0);
    push(3, "dis_frz3", M_CNT | M_IRQ, 32'd5, 1'b0, 1'b1, 3'd0, 1'b0);
    step(3);
    wr(2'd0, 16'h0010);
    push(0, "reen", M_CNT | M_EN, 32'd5, 1'b0, 1'b1, 3'd0, 1'b1);
    push(1, "reen4", M_CNT, 32'd4, 1'b0, 1'b1, 3'd0, 1'b1);
    push(2, "reen3", M_CNT, 32'd3, 1'b0, 1'b1, 3'd0, 1'b1);
    step(2);

    // Low-word reload gated by RLD_WR, then one-shot into HOLD
    bus.CLK_EN = 1'b0;
    wr(2'd1, 16'h0000);
    wr(2'd2, 16'h0002);
    push(0, "no_rld_wr", M_CNT, 32'd3, 1'b0, 1'b1, 3'd0, 1'b1);
    wr(2'd0, 16'h0030);
    wr(2'd2, 16'h0002);
    push(0, "rld_wr", M_CNT | M_IRQ, 32'd2, 1'b0, 1'b1, 3'd0, 1'b1);
    bus.CLK_EN = 1'b1;
    push(1, "os_1", M_CNT | M_IRQ, 32'd1, 1'b0, 1'b1, 3'd0, 1'b1);
    push(2, "os_0", M_CNT | M_IRQ, 32'd0, 1'b0, 1'b1, 3'd0, 1'b1);
    push(3, "os_irq", M_CNT | M_IRQ, 32'd0, 1'b1, 1'b1, 3'd0, 1'b1);
    push(4, "hold_1", M_CNT | M_IRQ, 32'd0, 1'b0, 1'b1, 3'd0, 1'b1);
    push(5, "hold_2", M_CNT | M_IRQ, 32'd0, 1'b0, 1'b1, 3'd0, 1'b1);
    push(6, "hold_3", M_CNT | M_IRQ, 32'd0, 1'b0, 1'b1, 3'd0, 1'b1);
    step(6);

    // VBL reload coincident with zero expiry, RLD_ZERO=0
    bus.CLK_EN = 1'b0;
    wr(2'd0, 16'h0070);
    wr(2'd2, 16'h0001);
    push(0, "hold_exit", M_CNT, 32'd1, 1'b0, 1'b1, 3'd0, 1'b1);
    wr(2'd0, 16'h0050);
    wr(2'd2, 16'h0100);
    push(0, "vbl_setup", M_CNT, 32'd1, 1'b0, 1'b1, 3'd0, 1'b1);
    bus.CLK_EN = 1'b1;
    push(1, "vbl_pre", M_CNT | M_IRQ, 32'd0, 1'b0, 1'b1, 3'd0, 1'b1);
    step();
    bus.VBL_START = 1'b1;
`ifdef TIMER_VBL_RELOAD_EN
    push(1, "vbl_hit", M_CNT | M_IRQ, 32'h100, 1'b1, 1'b1, 3'd0, 1'b1);
    step();
    bus.VBL_START = 1'b0;
    push(1, "vbl_run1", M_CNT | M_IRQ, 32'hFF, 1'b0, 1'b1, 3'd0, 1'b1);
    push(2, "vbl_run2", M_CNT | M_IRQ, 32'hFE, 1'b0, 1'b1, 3'd0, 1'b1);
`else
    push(1, "vbl_hit", M_CNT | M_IRQ, 32'h0, 1'b1, 1'b1, 3'd0, 1'b1);
    step();
    bus.VBL_START = 1'b0;
    push(1, "vbl_hold1", M_CNT | M_IRQ, 32'h0, 1'b0, 1'b1, 3'd0, 1'b1);
    push(2, "vbl_hold2", M_CNT | M_IRQ, 32'h0, 1'b0, 1'b1, 3'd0, 1'b1);
`endif
    step(2);

    // RELOAD=0 with RLD_ZERO fires on every CLK_EN; then async reset pulse mid-strobe
    bus.CLK_EN = 1'b0;
    wr(2'd1, 16'h0000);
    wr(2'd0, 16'h0030);
    wr(2'd2, 16'h0000);
    push(0, "rld0", M_CNT, 32'd0, 1'b0, 1'b1, 3'd0, 1'b1);
    wr(2'd0, 16'h0090);
    bus.CLK_EN = 1'b1;
    push(1, "z_irq1", M_CNT | M_IRQ, 32'd0, 1'b1, 1'b1, 3'd0, 1'b1);
    push(2, "z_irq2", M_CNT | M_IRQ, 32'd0, 1'b1, 1'b1, 3'd0, 1'b1);
    step(2);
    wr(2'd3, 16'h0006);
    bus.CLK_EN = 1'b0;
    push(0, "pre_rst", M_ALL, 32'd0, 1'b1, 1'b0, 3'b110, 1'b1);
    push(1, "rst_pulse", M_ALL, 32'd0, 1'b0, 1'b1, 3'd0, 1'b0);
    @(negedge CLK);
    #1 RESET = 1'b1;
    #2 RESET = 1'b0;
    step();

    // Drain the scoreboard within a bounded number of cycles
    for (int i = 0; i < 10 && sb.size() > 0; i++) step();
    if (sb.size() > 0) begin
      n_chk++; n_fail++;
      $display("FAIL drain: %0d checks still pending, required 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
